pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
Match-level sequencer for the Pong game. It owns the run/pause/serve/game-over state machine and the BCD scoreboard, which the top level currently implements with ad-hoc toggle logic. It consumes the debounced start button and point events from the ball/paddle asset logic. It drives that logic's run enable and round reset, and supplies digits to the seven-segment controller.

Parameters:
WIN_SCORE, 10, points needed to win the match (1..99)
SERVE_DELAY, 60, game_tick pulses held in SERVE before play resumes (1..255)

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-low
game_tick  in  1  one-clk-wide enable pulse at the game-logic rate
start_btn  in  1  debounced start button level, synchronous to clk
p1_point  in  1  one-clk pulse: player 1 scored (ball passed right edge)
p2_point  in  1  one-clk pulse: player 2 scored (ball passed left edge)
run  out  1  asset logic enable; high only in PLAY
round_rst  out  1  ball/paddle re-centre request
serve_dir  out  1  0 = ball launches toward player 1, 1 = toward player 2
p1_ones, p1_tens, p2_ones, p2_tens  out  4 each  BCD score digits
winner  out  2  00 none, 01 player 1, 10 player 2
state  out  3  encoded current state, for debug LEDs

Behaviour:
- Reset (clr low, async):
  - state = IDLE; all outputs 0; serve counter 0; edge-detect register 0.
- Start edge: start_btn high this cycle and low last cycle. Only rising edges act; holding the button has no further effect.
- IDLE (0): run=0. Start edge -> SERVE.
- SERVE (1): run=0.
  - round_rst goes high on entry and stays high through the first game_tick seen in SERVE, inclusive, so the slow domain samples it.
  - Serve counter clears on entry and increments on each game_tick.
  - When the counter equals SERVE_DELAY on a game_tick -> PLAY.
  - A start edge in SERVE is ignored.
- PLAY (2): run=1.
  - Exactly one of p1_point/p2_point high -> POINT.
  - Both high in the same cycle: no score, serve_dir unchanged -> SERVE.
  - Start edge with no point -> PAUSE. A point in the same cycle takes priority and the edge is dropped.
- PAUSE (3): run=0; scores held. Start edge -> PLAY. Point pulses are ignored.
- POINT (4), one cycle:
  - Increment the scorer's BCD pair: ones 9 -> 0 with tens+1; the pair saturates at 99.
  - serve_dir = toward the player who conceded (p1 scored -> 1).
  - Next: OVER if the new value (tens*10+ones) equals WIN_SCORE, else SERVE.
- OVER (5): run=0; winner latched to the scorer.
  - Start edge -> clear all four digits, winner=00, serve_dir=0 -> SERVE.
- Outside PLAY, point pulses never change the scores.
- Output timing: run, serve_dir, scores and winner are registered. run changes on the clk edge that enters or leaves PLAY (1-cycle latency from the triggering input).
- clr asserted in any state returns to IDLE immediately. A stray point pulse after release is ignored, because IDLE is not PLAY.
- Unused state codes 6 and 7 go to IDLE on the next clk.

Test Plan:
- Reset, then start edge -> state 1, round_rst high until the first game_tick. After 60 game_ticks, run=1 and state=2.
- In PLAY, p1_point pulse -> p1_ones=1, serve_dir=1, state passes 4 -> 1, run low for 60 ticks then high.
- 9 p1 points, then a start edge (PAUSE), a p1_point pulse (ignored), a start edge (PLAY), and a 10th point -> digits p1_tens=1, p1_ones=0, winner=01, state=5, run=0. A further start edge clears all digits and enters SERVE.
- p1_point and p2_point in the same cycle in PLAY -> scores unchanged, serve_dir unchanged, state=1.
- Start edge and p2_point in the same cycle in PLAY -> p2_ones=1, state=4 (not PAUSE). start_btn held high for 1000 cycles -> only one transition.
- clr pulsed low mid-SERVE with p1 at 7 -> all outputs 0 and state=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: IDLE/SERVE/PLAY/PAUSE/POINT/OVER FSM plus BCD scoreboard.
// All outputs registered (1-cycle latency from inputs); no backpressure, events outside PLAY are dropped.
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 10,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       game_tick,
    input  logic       start_btn,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic       run,
    output logic       round_rst,
    output logic       serve_dir,
    output logic [3:0] p1_ones,
    output logic [3:0] p1_tens,
    output logic [3:0] p2_ones,
    output logic [3:0] p2_tens,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_POINT = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_start_d, r_run, r_round_rst, r_serve_dir, r_scorer;
    logic [7:0] r_cnt;
    logic [3:0] r_p1_ones, r_p1_tens, r_p2_ones, r_p2_tens;
    logic [1:0] r_winner;

    logic       w_start_edge, w_enter_serve, w_clear;
    logic [7:0] w_cnt_inc;
    logic [3:0] w_sc_ones, w_sc_tens, w_inc_ones, w_inc_tens;
    logic [6:0] w_new_val;

    assign w_start_edge = start_btn & ~r_start_d;
    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_sc_ones    = r_scorer ? r_p2_ones : r_p1_ones;
    assign w_sc_tens    = r_scorer ? r_p2_tens : r_p1_tens;
    assign w_new_val    = 7'(w_inc_tens) * 7'd10 + 7'(w_inc_ones);

    // BCD increment of the scoring player's pair, saturating at 99
    always_comb begin
        w_inc_ones = w_sc_ones;
        w_inc_tens = w_sc_tens;
        if (!(w_sc_tens == 4'd9 && w_sc_ones == 4'd9)) begin
            if (w_sc_ones == 4'd9) begin
                w_inc_ones = 4'd0;
                w_inc_tens = w_sc_tens + 4'd1;
            end else begin
                w_inc_ones = w_sc_ones + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_enter_serve = 1'b0;
        w_clear       = 1'b0;
        case (r_state)
            S_IDLE: if (w_start_edge) begin
                w_state_nxt   = S_SERVE;
                w_enter_serve = 1'b1;
            end
            S_SERVE: if (game_tick && w_cnt_inc == 8'(SERVE_DELAY)) w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (p1_point ^ p2_point) begin
                    w_state_nxt = S_POINT;
                end else if (p1_point && p2_point) begin
                    w_state_nxt   = S_SERVE;
                    w_enter_serve = 1'b1;
                end else if (w_start_edge) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: if (w_start_edge) w_state_nxt = S_PLAY;
            S_POINT: begin
                if (w_new_val == 7'(WIN_SCORE)) begin
                    w_state_nxt = S_OVER;
                end else begin
                    w_state_nxt   = S_SERVE;
                    w_enter_serve = 1'b1;
                end
            end
            S_OVER: if (w_start_edge) begin
                w_state_nxt   = S_SERVE;
                w_enter_serve = 1'b1;
                w_clear       = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_start_d   <= 1'b0;
            r_run       <= 1'b0;
            r_round_rst <= 1'b0;
            r_serve_dir <= 1'b0;
            r_scorer    <= 1'b0;
            r_cnt       <= 8'd0;
            r_p1_ones   <= 4'd0;
            r_p1_tens   <= 4'd0;
            r_p2_ones   <= 4'd0;
            r_p2_tens   <= 4'd0;
            r_winner    <= 2'b00;
        end else begin
            r_start_d <= start_btn;
            r_run     <= (w_state_nxt == S_PLAY);

            // round_rst stays up until the slow domain has seen one game_tick
            if (w_enter_serve) begin
                r_cnt       <= 8'd0;
                r_round_rst <= 1'b1;
            end else if (r_state == S_SERVE && game_tick) begin
                r_cnt       <= w_cnt_inc;
                r_round_rst <= 1'b0;
            end

            if (r_state == S_PLAY && (p1_point ^ p2_point)) r_scorer <= p2_point;

            if (r_state == S_POINT) begin
                if (r_scorer) begin
                    r_p2_ones <= w_inc_ones;
                    r_p2_tens <= w_inc_tens;
                end else begin
                    r_p1_ones <= w_inc_ones;
                    r_p1_tens <= w_inc_tens;
                end
                r_serve_dir <= ~r_scorer;
                if (w_state_nxt == S_OVER) r_winner <= r_scorer ? 2'b10 : 2'b01;
            end

            if (w_clear) begin
                r_p1_ones   <= 4'd0;
                r_p1_tens   <= 4'd0;
                r_p2_ones   <= 4'd0;
                r_p2_tens   <= 4'd0;
                r_winner    <= 2'b00;
                r_serve_dir <= 1'b0;
            end
        end
    end

    assign run       = r_run;
    assign round_rst = r_round_rst;
    assign serve_dir = r_serve_dir;
    assign p1_ones   = r_p1_ones;
    assign p1_tens   = r_p1_tens;
    assign p2_ones   = r_p2_ones;
    assign p2_tens   = r_p2_tens;
    assign winner    = r_winner;
    assign state     = r_state;

endmodule
